// File: rtl/quadrature_step_gen_if.sv
// Step-command handshake between a command source and the quadrature step generator.
interface quadrature_step_gen_if;
    logic       step_valid;
    logic       step_ready;
    logic       step_dir;
    logic [7:0] step_num;
    logic       bounce_en;

    modport master (
        output step_valid,
        output step_dir,
        output step_num,
        output bounce_en,
        input  step_ready
    );

    modport slave (
        input  step_valid,
        input  step_dir,
        input  step_num,
        input  bounce_en,
        output step_ready
    );
endinterface

// File: rtl/quadrature_step_gen.sv
// Rotary-encoder emulator: turns step commands into idle-high Gray-coded A/B
// phase sequences, one 4-transition cycle per detent, with optional contact
// bounce before every settled edge. All timing advances only on tick cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a command; step_ready high
// ST_GLITCH | toggling the changing line once per tick before it settles
// ST_DWELL  | holding settled lines; also the wait for the first tick
module quadrature_step_gen #(
    parameter int DWELL    = 16,
    parameter int BOUNCE_N = 3,
    parameter int POS_W    = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    quadrature_step_gen_if.slave step,
    output logic                 enc_a,
    output logic                 enc_b,
    output logic                 busy,
    output logic                 done,
    output logic [POS_W-1:0]     position
);

    typedef enum logic [1:0] {ST_IDLE, ST_GLITCH, ST_DWELL} state_t;

    localparam logic [7:0] DWELL_LD    = 8'(DWELL);
    localparam logic [4:0] GLITCH_LAST = 5'(2 * BOUNCE_N - 1);
    localparam logic       BOUNCE_ON   = (BOUNCE_N > 0);

    state_t           state, state_n;
    logic [7:0]       cnt, cnt_n;
    logic [4:0]       gcnt, gcnt_n;
    logic [7:0]       rem, rem_n;
    logic [1:0]       idx, idx_n;
    logic             dir, dir_n;
    logic             bnc, bnc_n;
    logic             first, first_n;
    logic [1:0]       mask, mask_n;
    logic             a_n, b_n, done_n;
    logic [POS_W-1:0] pos_n;
    logic             go, settle;
    logic [1:0]       tgt;

    // Settled {A,B} after transition i of a detent; decrement is the increment
    // pattern with the two lines swapped.
    function automatic logic [1:0] detent_ab(input logic [1:0] i, input logic d);
        logic [1:0] v;
        case (i)
            2'd0:    v = 2'b01;
            2'd1:    v = 2'b00;
            2'd2:    v = 2'b10;
            default: v = 2'b11;
        endcase
        return d ? v : {v[0], v[1]};
    endfunction

    assign step.step_ready = (state == ST_IDLE);
    assign busy            = (state != ST_IDLE);
    assign tgt             = detent_ab(idx, dir);

    // Next-state and output decode; idx is the next transition to make.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gcnt_n  = gcnt;
        rem_n   = rem;
        idx_n   = idx;
        dir_n   = dir;
        bnc_n   = bnc;
        first_n = first;
        mask_n  = mask;
        a_n     = enc_a;
        b_n     = enc_b;
        done_n  = 1'b0;
        pos_n   = position;
        go      = 1'b0;
        settle  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (step.step_valid) begin
                    dir_n = step.step_dir;
                    bnc_n = step.bounce_en;
                    rem_n = step.step_num;
                    if (step.step_num == 8'd0) begin
                        done_n = 1'b1;
                    end else begin
                        // cnt=1 makes the first tick after acceptance start the detent
                        state_n = ST_DWELL;
                        cnt_n   = 8'd1;
                        idx_n   = 2'd0;
                        first_n = 1'b1;
                    end
                end
            end
            ST_GLITCH: begin
                if (tick) begin
                    if (gcnt == GLITCH_LAST) begin
                        settle = 1'b1;
                    end else begin
                        gcnt_n     = gcnt + 5'd1;
                        {a_n, b_n} = {enc_a, enc_b} ^ mask;
                    end
                end
            end
            ST_DWELL: begin
                if (tick) begin
                    if (cnt != 8'd1) begin
                        cnt_n = cnt - 8'd1;
                    end else if (first) begin
                        first_n = 1'b0;
                        go      = 1'b1;
                    end else if (idx != 2'd0) begin
                        go = 1'b1;
                    end else if (rem == 8'd1) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        rem_n = rem - 8'd1;
                        go    = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (go && bnc && BOUNCE_ON) begin
            state_n    = ST_GLITCH;
            gcnt_n     = 5'd0;
            mask_n     = tgt ^ {enc_a, enc_b};
            {a_n, b_n} = tgt;
        end else if (go) begin
            settle = 1'b1;
        end

        if (settle) begin
            {a_n, b_n} = tgt;
            state_n    = ST_DWELL;
            cnt_n      = DWELL_LD;
            idx_n      = idx + 2'd1;
            // enc_a is still the pre-transition value here, even after bounce
            if (enc_a && !tgt[1]) begin
                pos_n = dir ? position + POS_W'(1) : position - POS_W'(1);
            end
        end
    end

    // State and output registers; reset aborts any command and idles the lines high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 8'd0;
            gcnt     <= 5'd0;
            rem      <= 8'd0;
            idx      <= 2'd0;
            dir      <= 1'b0;
            bnc      <= 1'b0;
            first    <= 1'b0;
            mask     <= 2'b00;
            enc_a    <= 1'b1;
            enc_b    <= 1'b1;
            done     <= 1'b0;
            position <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            gcnt     <= gcnt_n;
            rem      <= rem_n;
            idx      <= idx_n;
            dir      <= dir_n;
            bnc      <= bnc_n;
            first    <= first_n;
            mask     <= mask_n;
            enc_a    <= a_n;
            enc_b    <= b_n;
            done     <= done_n;
            position <= pos_n;
        end
    end

endmodule

// File: tb/tb_quadrature_step_gen.sv
// Self-checking bench for quadrature_step_gen: a tick-indexed waveform model
// built from the detent tables, plus a narrow-position instance for wrap.
module tb_quadrature_step_gen;

    localparam int DW = 2;
    localparam int BN = 3;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic tick = 1'b0;

    always #5 clk = ~clk;

    quadrature_step_gen_if st();
    quadrature_step_gen_if wst();

    logic        enc_a, enc_b, busy, done;
    logic [23:0] position;
    logic        w_a, w_b, w_busy, w_done;
    logic [3:0]  w_pos;

    quadrature_step_gen #(.DWELL(DW), .BOUNCE_N(BN), .POS_W(24)) dut (
        .clk(clk), .rst(rst), .tick(tick), .step(st),
        .enc_a(enc_a), .enc_b(enc_b), .busy(busy), .done(done), .position(position)
    );

    quadrature_step_gen #(.DWELL(1), .BOUNCE_N(0), .POS_W(4)) dut_wrap (
        .clk(clk), .rst(rst), .tick(tick), .step(wst),
        .enc_a(w_a), .enc_b(w_b), .busy(w_busy), .done(w_done), .position(w_pos)
    );

    typedef struct packed {
        logic [1:0]  ab;
        logic [23:0] pos;
    } ent_t;

    int          checks    = 0;
    int          failures  = 0;
    int          tick_per  = 4;
    int          tick_ph   = 0;
    logic [23:0] pos_model = 24'd0;
    logic [1:0]  inc_seq [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [1:0]  dec_seq [4] = '{2'b10, 2'b00, 2'b01, 2'b11};

    // tick: periodic (tick_per>0) or random about one clk in three
    initial begin
        forever begin
            @(negedge clk);
            if (tick_per <= 0) begin
                tick = ($urandom_range(0, 2) == 0);
            end else begin
                tick_ph = (tick_ph + 1) % tick_per;
                tick    = (tick_ph == 0);
            end
        end
    end

    // Issue one command and follow it tick by tick until done. With hold=1 the
    // next command is presented throughout and must stall until done.
    task automatic run_cmd(input string nm, input logic d, input logic [7:0] n, input logic b,
                           input logic hold, input logic nd, input logic [7:0] nn, input logic nb);
        ent_t        q[$];
        logic [1:0]  cur, nv, e_ab;
        logic [23:0] p, e_pos;
        logic        fin;
        logic [28:0] obs, expv;
        int          k, total;

        cur = 2'b11;
        p   = pos_model;
        for (int det = 0; det < int'(n); det++) begin
            for (int tr = 0; tr < 4; tr++) begin
                nv = d ? inc_seq[tr] : dec_seq[tr];
                if (b) begin
                    for (int g = 0; g < BN; g++) begin
                        q.push_back('{ab: nv, pos: p});
                        q.push_back('{ab: cur, pos: p});
                    end
                end
                if (cur[1] && !nv[1]) p = d ? p + 24'd1 : p - 24'd1;
                for (int h = 0; h < DW; h++) q.push_back('{ab: nv, pos: p});
                cur = nv;
            end
        end
        total = q.size();

        st.step_valid = 1'b1;
        st.step_dir   = d;
        st.step_num   = n;
        st.bounce_en  = b;
        checks++;
        if (st.step_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_at_issue got %b exp 1", nm, st.step_ready);
        end
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            st.step_dir  = nd;
            st.step_num  = nn;
            st.bounce_en = nb;
        end else begin
            st.step_valid = 1'b0;
            st.step_dir   = 1'($urandom);
            st.step_num   = 8'($urandom);
            st.bounce_en  = 1'($urandom);
        end

        k = (n == 8'd0) ? 1 : 0;
        total = (n == 8'd0) ? 0 : total;
        for (int cyc = 0; ; cyc++) begin
            if (cyc > 20000) begin
                checks++;
                failures++;
                $display("FAIL %s timeout waiting for done after %0d cycles", nm, cyc);
                break;
            end
            fin = (k > total);
            if (k == 0) begin
                e_ab  = 2'b11;
                e_pos = pos_model;
            end else if (!fin) begin
                e_ab  = q[k-1].ab;
                e_pos = q[k-1].pos;
            end else begin
                e_ab  = 2'b11;
                e_pos = p;
            end
            obs  = {enc_a, enc_b, busy, done, st.step_ready, position};
            expv = {e_ab, !fin, fin, fin, e_pos};
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL %s cyc=%0d tick=%0d {ab,busy,done,ready,pos} got %b_%b_%b_%b_%h exp %b_%b_%b_%b_%h",
                         nm, cyc, k, obs[28:27], obs[26], obs[25], obs[24], obs[23:0],
                         expv[28:27], expv[26], expv[25], expv[24], expv[23:0]);
            end
            if (fin) break;
            @(posedge clk);
            if (tick) k++;
            @(negedge clk);
        end
        pos_model = p;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({enc_a, enc_b, busy, done, st.step_ready, position} !== {2'b11, 1'b0, 1'b0, 1'b1, 24'd0}) begin
            failures++;
            $display("FAIL reset got ab=%b busy=%b done=%b ready=%b pos=%h exp ab=11 busy=0 done=0 ready=1 pos=0",
                     {enc_a, enc_b}, busy, done, st.step_ready, position);
        end
        checks++;
        if ({w_a, w_b, w_busy, w_done, wst.step_ready, w_pos} !== {2'b11, 1'b0, 1'b0, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL reset_wrap got ab=%b busy=%b done=%b ready=%b pos=%h exp 11/0/0/1/0",
                     {w_a, w_b}, w_busy, w_done, wst.step_ready, w_pos);
        end
        pos_model = 24'd0;
    endtask

    task automatic test_decrement();
        tick_per = 4;
        run_cmd("decrement", 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        checks++;
        if (position !== 24'hFFFFFD) begin
            failures++;
            $display("FAIL decrement_pos got %h exp fffffd", position);
        end
    endtask

    task automatic test_increment();
        tick_per = 4;
        run_cmd("increment", 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_zero_back_to_back();
        tick_per = 0;
        run_cmd("zero", 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0);
        run_cmd("b2b_first", 1'b0, 8'd2, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1);
        run_cmd("b2b_second", 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_bounce();
        logic [23:0] pre;
        tick_per = 0;
        pre = position;
        run_cmd("bounce", 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        checks++;
        if (position !== pre + 24'd1) begin
            failures++;
            $display("FAIL bounce_pos got %h exp %h", position, pre + 24'd1);
        end
    endtask

    task automatic test_random();
        logic       cd [7];
        logic [7:0] cn [7];
        logic       cb [7];
        logic       ch [7];
        for (int i = 0; i < 7; i++) begin
            cd[i] = 1'($urandom);
            cn[i] = 8'($urandom_range(0, 3));
            cb[i] = 1'($urandom);
            ch[i] = (i < 6) ? 1'($urandom) : 1'b0;
        end
        for (int i = 0; i < 7; i++) begin
            tick_per = (i % 2 == 0) ? 0 : int'($urandom_range(1, 3));
            run_cmd("random", cd[i], cn[i], cb[i], ch[i],
                    cd[(i + 1) % 7], cn[(i + 1) % 7], cb[(i + 1) % 7]);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        tick_per = 1;
        run_cmd("pre_abort", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        st.step_valid = 1'b1;
        st.step_dir   = 1'b1;
        st.step_num   = 8'd2;
        st.bounce_en  = 1'b0;
        @(negedge clk);
        st.step_valid = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if ({enc_a, enc_b} === 2'b00) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (seen != 1) begin
            failures++;
            $display("FAIL abort_reach00 got ab=%b exp 00 within 200 cycles", {enc_a, enc_b});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({enc_a, enc_b, busy, done, position} !== {2'b11, 1'b0, 1'b0, 24'd0}) begin
            failures++;
            $display("FAIL abort_in_reset got ab=%b busy=%b done=%b pos=%h exp 11/0/0/0",
                     {enc_a, enc_b}, busy, done, position);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({enc_a, enc_b, busy, done, st.step_ready, position} !== {2'b11, 1'b0, 1'b0, 1'b1, 24'd0}) begin
            failures++;
            $display("FAIL abort_release got ab=%b busy=%b done=%b ready=%b pos=%h exp 11/0/0/1/0",
                     {enc_a, enc_b}, busy, done, st.step_ready, position);
        end
        pos_model = 24'd0;
        run_cmd("post_abort", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [3:0] wm;
        logic       cmd_dir [2] = '{1'b1, 1'b0};
        logic [7:0] cmd_num [2] = '{8'd8, 8'd1};
        int         dones;
        tick_per = 1;
        wm = 4'd0;
        for (int c = 0; c < 2; c++) begin
            wst.step_valid = 1'b1;
            wst.step_dir   = cmd_dir[c];
            wst.step_num   = cmd_num[c];
            wst.bounce_en  = 1'b1;
            @(negedge clk);
            wst.step_valid = 1'b0;
            for (int i = 0; i < int'(cmd_num[c]); i++) wm = cmd_dir[c] ? wm + 4'd1 : wm - 4'd1;
            dones = 0;
            for (int cyc = 0; cyc < 400 && !w_done; cyc++) @(negedge clk);
            repeat (4) begin
                if (w_done === 1'b1) dones++;
                @(negedge clk);
            end
            checks++;
            if (dones != 1) begin
                failures++;
                $display("FAIL wrap_done_count cmd=%0d got %0d exp 1", c, dones);
            end
            checks++;
            if (w_pos !== wm) begin
                failures++;
                $display("FAIL wrap_pos cmd=%0d got %h exp %h", c, w_pos, wm);
            end
        end
    endtask

    initial begin
        st.step_valid  = 1'b0;
        st.step_dir    = 1'b0;
        st.step_num    = 8'd0;
        st.bounce_en   = 1'b0;
        wst.step_valid = 1'b0;
        wst.step_dir   = 1'b0;
        wst.step_num   = 8'd0;
        wst.bounce_en  = 1'b0;

        test_reset();
        test_decrement();
        test_increment();
        test_zero_back_to_back();
        test_bounce();
        test_random();
        test_reset_mid();
        test_wrap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
